puf_response_uart_tx: RTL and testbench

Downstream stage of controller_simple. It takes the 64-bit PUF response word through a valid/ready handshake and serializes it onto a UART TX line as 8N1 frames. The word is sent as RESP_WIDTH/8 bytes, least-significant byte first. It gives the PUF lab a path from the response to a host PC, replacing simulation-only readout of the response.

---
 rtl/puf_response_uart_tx_if.sv | 12 +
 rtl/puf_response_uart_tx.sv | 123 ++++++++++++
 tb/tb_puf_response_uart_tx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/puf_response_uart_tx_if.sv
// Valid/ready channel carrying one PUF response word from controller_simple
// to the UART transmitter.
interface puf_response_uart_tx_if #(
  parameter int RESP_WIDTH = 64
);
  logic [RESP_WIDTH-1:0] resp_data;
  logic                  resp_valid;
  logic                  resp_ready;

  modport master (output resp_data, output resp_valid, input resp_ready);
  modport slave  (input resp_data, input resp_valid, output resp_ready);
endinterface

// File: rtl/puf_response_uart_tx.sv
// Serializes a PUF response word onto an 8N1 UART line, least-significant
// byte first, with a one-cycle done pulse after the final stop bit.
module puf_response_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int RESP_WIDTH   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  puf_response_uart_tx_if.slave resp,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);
  localparam int NBYTES = RESP_WIDTH / 8;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [BYTE_W-1:0]     byte_q, byte_d;
  logic [RESP_WIDTH-1:0] shreg_q, shreg_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  bit_end;

  assign resp.resp_ready = (state_q == IDLE) && !rst;
  assign accept          = resp.resp_valid && resp.resp_ready;
  assign bit_end         = (baud_q == BAUD_LAST);
  assign tx              = tx_q;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;

  // tx_d carries the line level of the state being entered, so tx stays registered
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          shreg_d = resp.resp_data;
          byte_d  = '0;
          baud_d  = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          // Shift out the finished bit so the next bit (or next byte's bit 0) sits at [0]
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shreg_q[1];
          end
        end
      end
      STOP: begin
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          baud_d = '0;
          if (byte_q != BYTE_LAST) begin
            byte_d  = byte_q + 1'b1;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end
endmodule

// File: tb/tb_puf_response_uart_tx.sv
// Randomized bench for puf_response_uart_tx against an 8N1 line model.
module tb_puf_response_uart_tx;
  localparam int CPB   = 4;
  localparam int FRAME = 8 * 10 * CPB;

  logic clk = 1'b0;
  logic rst;
  logic tx, busy, done;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  puf_response_uart_tx_if #(.RESP_WIDTH(64)) rif ();

  puf_response_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .RESP_WIDTH  (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .resp(rif),
    .tx  (tx),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected line level i cycles after the first start-bit cycle of word w
  function automatic logic exp_tx(input logic [63:0] w, input int i);
    int f, s;
    f = i / (10 * CPB);
    s = (i % (10 * CPB)) / CPB;
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return w[f * 8 + s - 1];
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (rif.resp_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 64'(n < 5000), 64'd1);
  endtask

  task automatic xfer(input logic [63:0] w, input bit chained, input bit keep_valid,
                      input logic [63:0] mid_w);
    int busy_n, done_n, low_n, exp_low, wave_err, f, s;
    logic [63:0] dec;
    busy_n = 0; done_n = 0; low_n = 0; exp_low = 0; wave_err = 0; dec = '0;
    if (!chained) begin
      @(negedge clk);
      rif.resp_data  = w;
      rif.resp_valid = 1'b1;
      wait_ready();
    end
    @(negedge clk);
    if (!keep_valid) rif.resp_valid = 1'b0;
    chk("first_start", 64'(tx), 64'd0);
    for (int i = 0; i < FRAME; i++) begin
      if (tx !== exp_tx(w, i)) wave_err++;
      if (tx === 1'b0) low_n++;
      if (!exp_tx(w, i)) exp_low++;
      if (busy === 1'b1) busy_n++;
      if (done !== 1'b0) done_n++;
      if (i % CPB == CPB / 2) begin
        f = i / (10 * CPB);
        s = (i % (10 * CPB)) / CPB;
        if (s >= 1 && s <= 8) dec[f * 8 + s - 1] = tx;
      end
      if (keep_valid && i == 150) rif.resp_data = mid_w;
      @(negedge clk);
    end
    chk("decoded_word", dec, w);
    chk("wave_errs", 64'(wave_err), 64'd0);
    chk("low_cycles", 64'(low_n), 64'(exp_low));
    chk("busy_cycles", 64'(busy_n), 64'(FRAME));
    chk("early_done", 64'(done_n), 64'd0);
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("ready_at_done", 64'(rif.resp_ready), 64'd1);
    chk("tx_at_done", 64'(tx), 64'd1);
    if (!keep_valid) begin
      @(negedge clk);
      chk("done_clear", 64'(done), 64'd0);
    end
  endtask

  task automatic reset_mid_frame(input logic [63:0] w);
    int bad;
    @(negedge clk);
    rif.resp_data  = w;
    rif.resp_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    rif.resp_valid = 1'b0;
    // Index 97 lies inside data bit 3 of byte 2
    repeat (97) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_tx", 64'(tx), 64'(exp_tx(w, 97)));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(rif.resp_ready), 64'd0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("post_rst_quiet", 64'(bad), 64'd0);
  endtask

  initial begin
    logic [63:0] rw;
    rst            = 1'b1;
    rif.resp_valid = 1'b0;
    rif.resp_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", 64'(tx), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_ready", 64'(rif.resp_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(rif.resp_ready), 64'd1);

    xfer(64'h0123456789ABCDEF, 1'b0, 1'b0, '0);

    xfer(64'h0123456789ABCDEF, 1'b0, 1'b1, 64'hFFFF_0000_FFFF_0000);
    xfer(64'hFFFF_0000_FFFF_0000, 1'b1, 1'b0, '0);

    reset_mid_frame(64'h0123456789ABCDEF);
    xfer(64'h00000000000000A5, 1'b0, 1'b0, '0);

    xfer(64'h0, 1'b0, 1'b0, '0);
    xfer(64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, '0);

    for (int k = 0; k < 5; k++) begin
      rw = {$urandom, $urandom};
      repeat ($urandom_range(0, 5)) @(negedge clk);
      xfer(rw, 1'b0, 1'b0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
